display_frame_seq: RTL

//  Sequential, parametrised 7-seg frame generator for the lock front panel. Buffers the

---
 rtl/display_frame_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/display_frame_seq.sv
// -----------------------------------------------------------------------------
// display_frame_seq
//   Sequential 7-seg frame generator for the lock front panel. It buffers the
//   entered code one digit at a time and shows each committed digit as DASH.
//   The digit at the cursor previews the live symbol. OPEN/ERR messages are
//   held for MSG_CYCLES clocks. The frame output is registered and goes to the
//   digit-scan driver. The stored code goes to the code comparator.
//
//   Optional feature macro: CURSOR_BLINK_EN
//     When defined, the preview digit alternates between sym_in and BLANK
//     every BLINK_DIV cycles. When undefined, the preview is steady and no
//     blink counter is built.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous, active-high reset
//   sym_in      live symbol from keypad/switches
//   sym_commit  1-cycle pulse: store sym_in at the cursor
//   clear       1-cycle pulse: empty the buffer and return to ENTRY
//   show_open   1-cycle pulse: display OPEN_MSG
//   show_err    1-cycle pulse: display ERR_MSG
//   ext_sel     level: frame follows ext_frame
//   ext_frame   external raw frame
//   frame       registered display frame, digit0 in MSBs
//   code        stored code, digit0 in MSBs
//   cursor      committed digit count
//   entry_full  cursor == NUM_DIGITS
//   busy        a message is being shown
// -----------------------------------------------------------------------------
module display_frame_seq #(
  parameter int NUM_DIGITS = 4,
  parameter int SYM_W      = 5,
  parameter int MSG_CYCLES = 100_000_000,
  parameter int BLINK_DIV  = 12_500_000,
  parameter logic [NUM_DIGITS*SYM_W-1:0] OPEN_MSG = 20'b01100111000010101101,
  parameter logic [NUM_DIGITS*SYM_W-1:0] ERR_MSG  = 20'b00000100000111011110
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SYM_W-1:0]              sym_in,
  input  logic                          sym_commit,
  input  logic                          clear,
  input  logic                          show_open,
  input  logic                          show_err,
  input  logic                          ext_sel,
  input  logic [NUM_DIGITS*SYM_W-1:0]   ext_frame,
  output logic [NUM_DIGITS*SYM_W-1:0]   frame,
  output logic [NUM_DIGITS*SYM_W-1:0]   code,
  output logic [$clog2(NUM_DIGITS+1)-1:0] cursor,
  output logic                          entry_full,
  output logic                          busy
);

  localparam int FRAME_W = NUM_DIGITS * SYM_W;
  localparam int CUR_W   = $clog2(NUM_DIGITS + 1);
  localparam int TIMER_W = (MSG_CYCLES > 1) ? $clog2(MSG_CYCLES) : 1;

  localparam logic [SYM_W-1:0] BLANK = '1;
  localparam logic [SYM_W-1:0] DASH  = {1'b1, {(SYM_W-2){1'b0}}, 1'b1};

  typedef enum logic {
    ENTRY = 1'b0,
    MSG   = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   msg_q, msg_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [FRAME_W-1:0]   code_q, code_d;
  logic [CUR_W-1:0]     cursor_q, cursor_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 full_q;
  logic                 blink_show;

  assign full_q = (cursor_q == CUR_W'(NUM_DIGITS));

  // Next-state logic. Priority: clear > show_err > show_open > per-state work.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so that no path
    // leaves a value unassigned and infers a latch.
    state_d  = state_q;
    msg_d    = msg_q;
    timer_d  = timer_q;
    code_d   = code_q;
    cursor_d = cursor_q;

    if (clear) begin
      state_d  = ENTRY;
      code_d   = '0;
      cursor_d = '0;
      timer_d  = '0;
    end else if (show_err) begin
      state_d = MSG;
      msg_d   = ERR_MSG;
      timer_d = '0;
    end else if (show_open) begin
      state_d = MSG;
      msg_d   = OPEN_MSG;
      timer_d = '0;
    end else begin
      unique case (state_q)
        ENTRY: begin
          // A commit on a full buffer is dropped; the cursor never wraps.
          if (sym_commit && !full_q) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (cursor_q == CUR_W'(i))
                code_d[(NUM_DIGITS-1-i)*SYM_W +: SYM_W] = sym_in;
            end
            cursor_d = cursor_q + 1'b1;
          end
        end
        MSG: begin
          // timer_q counts completed MSG cycles, so the last one is MSG_CYCLES-1.
          if (timer_q == TIMER_W'(MSG_CYCLES - 1)) begin
            state_d  = ENTRY;
            code_d   = '0;
            cursor_d = '0;
            timer_d  = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = ENTRY;
      endcase
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  // Free-running half-period counter; commit and clear restart it in the
  // "show" phase so that a fresh cursor position is visible at once.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (sym_commit || clear) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_show = blink_phase_d;
`else
  assign blink_show = 1'b1;
`endif

  // The frame is built from next-state values. This way every input reaches
  // the registered frame exactly one clock later.
  always_comb begin
    frame_d = '1;
    if (ext_sel) begin
      frame_d = ext_frame;
    end else if (state_d == MSG) begin
      frame_d = msg_d;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (CUR_W'(i) < cursor_d)
          frame_d[(NUM_DIGITS-1-i)*SYM_W +: SYM_W] = DASH;
        else if (CUR_W'(i) == cursor_d && blink_show)
          frame_d[(NUM_DIGITS-1-i)*SYM_W +: SYM_W] = sym_in;
        else
          frame_d[(NUM_DIGITS-1-i)*SYM_W +: SYM_W] = BLANK;
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments only. This way all
  // flops sample the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ENTRY;
      msg_q    <= '0;
      timer_q  <= '0;
      code_q   <= '0;
      cursor_q <= '0;
      frame_q  <= '1;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      timer_q  <= timer_d;
      code_q   <= code_d;
      cursor_q <= cursor_d;
      frame_q  <= frame_d;
    end
  end

  assign frame      = frame_q;
  assign code       = code_q;
  assign cursor     = cursor_q;
  assign entry_full = full_q;
  assign busy       = (state_q == MSG);

endmodule
